// File: rtl/fifo_if.sv
// FifoIO: write/read handshake bundle between a producer, a FIFO and a consumer.
// The FIFO side uses the fifo modport; each end uses its own modport.
interface FifoIO #(
  parameter int DATA_WIDTH = 16
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;

  modport fifo (
    input  wr_en,
    input  wr_data,
    input  rd_en,
    output rd_data,
    output full,
    output empty
  );

  modport producer (
    output wr_en,
    output wr_data,
    input  full
  );

  modport consumer (
    output rd_en,
    input  rd_data,
    input  empty
  );
endinterface

// File: rtl/fifo.sv
// fifo: single-clock first-word-fall-through buffer for a NoC router port.
// The depth is any value >= 2; pointers wrap explicitly rather than by overflow.
module fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_SIZE  = 4
) (
  input logic clk,
  input logic rst,
  FifoIO.fifo fifo_io
);

  localparam int PW = $clog2(FIFO_SIZE);
  localparam int CW = $clog2(FIFO_SIZE + 1);
  localparam logic [PW-1:0] LAST  = PW'(FIFO_SIZE - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_SIZE);

  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic full;
  logic empty;
  logic do_wr;
  logic do_rd;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  // A full FIFO still takes a write when the head is popped on the same edge.
  assign do_rd = fifo_io.rd_en && !empty;
  assign do_wr = fifo_io.wr_en && (!full || do_rd);

  assign fifo_io.full    = full;
  assign fifo_io.empty   = empty;
  assign fifo_io.rd_data = empty ? '0 : mem[rd_ptr];

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= fifo_io.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= nxt(rd_ptr);
      end
      if (do_wr && !do_rd) begin
        count <= count + CW'(1);
      end else if (do_rd && !do_wr) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed and model-checked stimulus for the 4-deep FWFT fifo.
// Every expectation is a hand-computed constant or comes from a local queue model.
module tb_fifo;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  FifoIO #(.DATA_WIDTH(16)) bus ();

  fifo #(
    .DATA_WIDTH(16),
    .FIFO_SIZE (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .fifo_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  int q[$];
  int nw;
  int last;
  int v;
  int cyc;
  bit do_rd;
  bit do_wr;

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;

    // reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_rdata", bus.rd_data, 0);
    tick();

    // single write / read
    wr(16'h0005);
    chk("w1_empty", bus.empty, 0);
    chk("w1_rdata", bus.rd_data, 16'h0005);
    rd();
    chk("r1_empty", bus.empty, 1);
    chk("r1_rdata", bus.rd_data, 0);

    // fill to full, drop a 5th write
    for (int i = 0; i < 4; i++) begin
      chk("fill_nfull", bus.full, 0);
      wr(16'(i));
    end
    chk("fill_full", bus.full, 1);
    wr(16'd4);
    chk("drop_full", bus.full, 1);
    chk("drop_head", bus.rd_data, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", bus.rd_data, i);
      rd();
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_rdata", bus.rd_data, 0);

    // simultaneous read and write while full
    for (int i = 10; i < 14; i++) wr(16'(i));
    chk("sf_full0", bus.full, 1);
    chk("sf_head0", bus.rd_data, 10);
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'd14;
    bus.rd_en   = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("sf_head1", bus.rd_data, 11);
    chk("sf_full1", bus.full, 1);
    for (int i = 11; i < 15; i++) begin
      chk("sf_drain", bus.rd_data, i);
      rd();
    end
    chk("sf_empty", bus.empty, 1);

    // simultaneous read and write while empty
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'd7;
    bus.rd_en   = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    chk("se_empty", bus.empty, 0);
    chk("se_full", bus.full, 0);
    chk("se_rdata", bus.rd_data, 7);
    tick();
    chk("se_pop", bus.empty, 1);
    for (int i = 8; i < 11; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'(i);
      tick();
      bus.wr_en = 1'b0;
      chk("se_pass", bus.rd_data, i);
      tick();
      chk("se_gone", bus.empty, 1);
    end
    bus.rd_en = 1'b0;

    // asynchronous reset with 2 words stored
    wr(16'h00aa);
    wr(16'h00bb);
    chk("ar_pre", bus.rd_data, 16'h00aa);
    rst = 1'b1;
    #1;
    chk("ar_empty", bus.empty, 1);
    chk("ar_rdata", bus.rd_data, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_after", bus.empty, 1);

    // stress with random reads, checked against a queue model
    nw   = 0;
    last = -1;
    cyc  = 0;
    q.delete();
    while ((nw < 100 || q.size() > 0) && cyc < 2000) begin
      bus.wr_en   = (cyc % 2 == 0) && (nw < 100);
      bus.wr_data = 16'(nw);
      bus.rd_en   = (nw >= 100) ||
                    ($urandom_range(0, 9) < 4);
      #2;
      chk("st_rdata", bus.rd_data,
          q.size() > 0 ? q[0] : 0);
      chk("st_full", bus.full, q.size() == 4);
      chk("st_empty", bus.empty, q.size() == 0);
      do_rd = bus.rd_en && q.size() > 0;
      do_wr = bus.wr_en && (q.size() < 4 || do_rd);
      if (do_rd) begin
        v = q.pop_front();
        chk("st_order", v > last, 1);
        last = v;
      end
      if (do_wr) q.push_back(nw);
      if (bus.wr_en) nw++;
      tick();
      cyc++;
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("st_done", cyc < 2000, 1);
    chk("st_last", last >= 90, 1);
    chk("st_fin_empty", bus.empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock FIFO used as the per-port buffer in the NoC router datapath.
- Connects to producer and consumer through the FifoIO interface; the block uses the fifo modport.
- Read side is first-word-fall-through: the head entry is always visible on rd_data while the FIFO is non-empty.

Parameters:
- DATA_WIDTH, 16, width of each stored word; must match the DATA_WIDTH of the connected FifoIO instance.
- FIFO_SIZE, 4, depth in words; any integer >= 2, power of two not required.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- fifo_io  interface  FifoIO.fifo modport  bundle of the signals below.
- fifo_io.wr_en  input  1  write request.
- fifo_io.wr_data  input  DATA_WIDTH  word to write.
- fifo_io.full  output  1  high when occupancy == FIFO_SIZE.
- fifo_io.rd_en  input  1  read (pop) request.
- fifo_io.rd_data  output  DATA_WIDTH  head word (FWFT).
- fifo_io.empty  output  1  high when occupancy == 0.

FifoIO interface:
- Parameter DATA_WIDTH, default 16. Declares the six signals above.
- Modport fifo: wr_en, wr_data, rd_en as inputs; rd_data, full, empty as outputs.
- Modport producer: wr_en, wr_data as outputs; full as input.
- Modport consumer: rd_en as output; rd_data, empty as inputs.

Behaviour:
- Storage: FIFO_SIZE x DATA_WIDTH array, write pointer wr_ptr, read pointer rd_ptr, occupancy counter count (0..FIFO_SIZE).
- Reset (rst high, asynchronous): wr_ptr=0, rd_ptr=0, count=0, so empty=1 and full=0. rd_data=0. Memory contents need not be cleared. Reset asserted mid-operation discards all contents immediately.
- Write: on a rising edge with wr_en=1 and accept_wr, mem[wr_ptr] <= wr_data and wr_ptr advances.
- Read: on a rising edge with rd_en=1 and empty=0, rd_ptr advances. The popped word is the value on rd_data before that edge.
- Pointer wrap: a pointer equal to FIFO_SIZE-1 wraps to 0; the next value is not computed modulo a power of two.
- rd_data (combinational): mem[rd_ptr] when empty=0; all-zero when empty=1.
- Latency: a word written at edge N appears on rd_data after edge N if the FIFO was empty. There is no write-to-read bypass within the same cycle.
- accept_wr = !full, or full with a simultaneous valid read. When full and both wr_en and rd_en are high, both operations occur and count is unchanged.
- Write while full without a read: ignored; no pointer or data change.
- Read while empty: ignored. When empty and both wr_en and rd_en are high, only the write occurs and count becomes 1.
- count: +1 on write only, -1 on read only, unchanged when both or neither occur.
- full and empty are derived combinationally from count.
- Data order is strictly preserved; no overflow or underflow error outputs.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release -> empty=1, full=0, rd_data=0. Assert rst mid-stream with 2 words stored -> empty=1 immediately, without waiting for a clock edge.
- Single write/read: write 0x0005 -> after that edge empty=0, rd_data=0x0005. Pulse rd_en for one cycle -> empty=1, rd_data=0.
- Fill to full: write 0,1,2,3 with no reads -> full=1 after the 4th write. A 5th write of 4 is dropped. Reading 4 times yields 0,1,2,3, then empty=1.
- Wrap-around: write one word every 2 cycles for values 0..99 while reading at random intervals of 0-50 time units -> read sequence is strictly increasing with no duplicates or gaps, excluding words dropped while full. Pointers wrap past 3 many times.
- Simultaneous read and write when full (contents 10,11,12,13): write 14 with rd_en=1 -> rd_data goes 10 then 11, full stays 1. Draining gives 11,12,13,14.
- Simultaneous read and write when empty: write 7 with rd_en=1 -> after the edge count=1 and rd_data=7. rd_en held high continuously afterward -> each following write is popped on the next edge.
